mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 2: number of requesting clients (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 8: data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles before a forced error completion (1..65535).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port cli_addr, input, NUM_CLIENTS*ADDR_W: per-client address; client i occupies slice i.
REQ-008 SHALL have port cli_wdata, input, NUM_CLIENTS*DATA_W: per-client write data.
REQ-009 SHALL have port cli_read_en, input, NUM_CLIENTS: per-client read request level.
REQ-010 SHALL have port cli_write_en, input, NUM_CLIENTS: per-client write request level.
REQ-011 SHALL have port cli_ready, output, NUM_CLIENTS: per-client one-cycle completion pulse.
REQ-012 SHALL have port cli_rdata, output, DATA_W: read data, shared by all clients, valid while any cli_ready bit is high.
REQ-013 SHALL have port cli_err, output, 1: timeout flag, valid with cli_ready.
REQ-014 SHALL have port grant, output, NUM_CLIENTS: one-hot owner of the memory port; zero when idle.
REQ-015 SHALL have downstream ports mem_addr (output, ADDR_W), mem_data_in (output, DATA_W), mem_data_out (input, DATA_W), mem_read_en (output, 1), mem_write_en (output, 1), mem_ready (input, 1).

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: SHALL leave the state unchanged if no client is requesting; otherwise SHALL select a winner, register its address, write data and operation, set grant, and move to ISSUE.
REQ-018 A client with both read_en and write_en high SHALL be treated as a write.
REQ-019 ISSUE: SHALL drive mem_read_en or mem_write_en high for exactly one cycle, ignore mem_ready, clear the timeout counter, and move to WAIT.
REQ-020 WAIT: mem_ready=1 SHALL capture mem_data_out (reads only; writes capture 0) and move to RESP.
REQ-021 WAIT: the counter SHALL increment each cycle; on reaching TIMEOUT_CYCLES without mem_ready, the block SHALL move to RESP with the error flag set and captured data 0.
REQ-022 RESP: SHALL pulse cli_ready[winner] for one cycle with cli_rdata and cli_err driven, clear grant, and return to IDLE.
REQ-023 Latency: a request seen in IDLE at cycle 0 SHALL produce mem_*_en at cycle 1; mem_ready at cycle k≥2 SHALL produce cli_ready at cycle k+1.
REQ-024 mem_addr and mem_data_in SHALL stay stable from ISSUE through RESP.
REQ-025 Changes to client inputs after the grant SHALL be ignored until RESP.
REQ-026 Clients SHALL hold their request until cli_ready; a request dropped before it is granted SHALL have no effect.
REQ-027 A client still requesting in the cycle after RESP SHALL be treated as a new request.
REQ-028 At most one cli_ready bit SHALL be high in any cycle.
REQ-029 Outside RESP, cli_ready, cli_err and cli_rdata SHALL be 0.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force: state IDLE, all outputs 0, timeout counter 0, round-robin pointer NUM_CLIENTS-1.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction without any cli_ready pulse.
REQ-032 After rst_n rises, the first arbitration SHALL occur on the first clock edge.

Configuration
REQ-033 With MEM_ARB_ROUND_ROBIN_EN defined: the search SHALL start at the pointer plus 1 modulo NUM_CLIENTS, and the pointer SHALL update to the winner at grant.
REQ-034 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority SHALL apply, lowest index wins, and no pointer register SHALL exist.

Verification
REQ-035 Single read: client 0 reads addr 0x10, memory returns 0xA5 with mem_ready at cycle 3 -> mem_read_en at cycle 1 only, cli_ready[0] at cycle 4, cli_rdata=0xA5, cli_err=0.
REQ-036 Single write: client 1 writes 0x3C to 0x20 -> mem_write_en pulse with mem_addr=0x20 and mem_data_in=0x3C; cli_ready[1] one cycle after mem_ready; cli_rdata=0.
REQ-037 Contention, round-robin on: clients 0 and 1 request continuously -> grants alternate 0,1,0,1; round-robin off -> client 0 always wins.
REQ-038 Timeout: TIMEOUT_CYCLES=4, mem_ready never asserts -> cli_ready pulses with cli_err=1 and cli_rdata=0, then the next request is served normally.
REQ-039 Reset mid-WAIT: rst_n low during WAIT -> grant=0 immediately, no cli_ready pulse; after release, client 0 is served first.
REQ-040 Simultaneous read_en and write_en on client 0 -> a single mem_write_en pulse and mem_read_en never asserted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Multi-client arbiter in front of a single request/ready memory port, with a per-transaction timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module mem_arbiter #(
    parameter int NUM_CLIENTS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata,
    input  logic [NUM_CLIENTS-1:0]        cli_read_en,
    input  logic [NUM_CLIENTS-1:0]        cli_write_en,
    output logic [NUM_CLIENTS-1:0]        cli_ready,
    output logic [DATA_W-1:0]             cli_rdata,
    output logic                          cli_err,
    output logic [NUM_CLIENTS-1:0]        grant,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data_in,
    input  logic [DATA_W-1:0]             mem_data_out,
    output logic                          mem_read_en,
    output logic                          mem_write_en,
    input  logic                          mem_ready
);

    localparam int WIN_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [WIN_W-1:0]       winner_q, winner_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   write_q, write_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [15:0]            cnt_q, cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [WIN_W-1:0]       ptr_q, ptr_d;
`endif

    logic [NUM_CLIENTS-1:0] req;
    logic                   pick_valid;
    logic [WIN_W-1:0]       pick_idx;
    logic [NUM_CLIENTS-1:0] winner_onehot;
    int                     cand;

    assign req = cli_read_en | cli_write_en;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Search starts just after the last winner, wrapping around.
            cand = int'(ptr_q) + 1 + i;
            if (cand >= NUM_CLIENTS) begin
                cand = cand - NUM_CLIENTS;
            end
`else
            cand = i;
`endif
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = WIN_W'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    addr_d   = cli_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d  = cli_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    write_d  = cli_write_en[pick_idx];
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    ptr_d    = pick_idx;
`endif
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    rdata_d = write_q ? '0 : mem_data_out;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q >= 16'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            winner_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q    <= WIN_W'(NUM_CLIENTS - 1);
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // All outputs decode from registered state so reset clears them at once.
    assign winner_onehot = NUM_CLIENTS'(1) << winner_q;
    assign grant         = (state_q != S_IDLE) ? winner_onehot : '0;
    assign cli_ready     = (state_q == S_RESP) ? winner_onehot : '0;
    assign cli_rdata     = (state_q == S_RESP) ? rdata_q : '0;
    assign cli_err       = (state_q == S_RESP) ? err_q : 1'b0;
    assign mem_addr      = (state_q != S_IDLE) ? addr_q : '0;
    assign mem_data_in   = (state_q != S_IDLE) ? wdata_q : '0;
    assign mem_read_en   = (state_q == S_ISSUE) && !write_q;
    assign mem_write_en  = (state_q == S_ISSUE) && write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, write, contention, timeout, reset abort, read+write collision.
module tb_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*AW-1:0] cli_addr;
    logic [N*DW-1:0] cli_wdata;
    logic [N-1:0]    cli_read_en;
    logic [N-1:0]    cli_write_en;
    logic [N-1:0]    cli_ready;
    logic [DW-1:0]   cli_rdata;
    logic            cli_err;
    logic [N-1:0]    grant;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;
    logic            mem_read_en;
    logic            mem_write_en;
    logic            mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cli_addr(cli_addr), .cli_wdata(cli_wdata),
        .cli_read_en(cli_read_en), .cli_write_en(cli_write_en),
        .cli_ready(cli_ready), .cli_rdata(cli_rdata), .cli_err(cli_err),
        .grant(grant),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] exp_g;
        int           waited;

        rst_n        = 1'b0;
        cli_addr     = '0;
        cli_wdata    = '0;
        cli_read_en  = '0;
        cli_write_en = '0;
        mem_data_out = '0;
        mem_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_ready", 64'(cli_ready), 64'h0);
        check("rst_rden", 64'(mem_read_en), 64'h0);
        check("rst_addr", 64'(mem_addr), 64'h0);
        rst_n = 1'b1;

        // Single read, client 0 (cycle 0 = request seen in IDLE)
        cli_read_en[0]    = 1'b1;
        cli_addr[0 +: AW] = 32'h10;
        tick;
        check("rd_c1_rden", 64'(mem_read_en), 64'h1);
        check("rd_c1_wren", 64'(mem_write_en), 64'h0);
        check("rd_c1_addr", 64'(mem_addr), 64'h10);
        check("rd_c1_grant", 64'(grant), 64'h1);
        tick;
        check("rd_c2_rden", 64'(mem_read_en), 64'h0);
        check("rd_c2_ready", 64'(cli_ready), 64'h0);
        tick;
        mem_ready    = 1'b1;
        mem_data_out = 8'hA5;
        check("rd_c3_ready", 64'(cli_ready), 64'h0);
        tick;
        mem_ready    = 1'b0;
        mem_data_out = 8'h00;
        check("rd_c4_ready", 64'(cli_ready), 64'h1);
        check("rd_c4_rdata", 64'(cli_rdata), 64'hA5);
        check("rd_c4_err", 64'(cli_err), 64'h0);
        check("rd_c4_addr", 64'(mem_addr), 64'h10);
        cli_read_en[0] = 1'b0;
        tick;
        check("rd_c5_ready", 64'(cli_ready), 64'h0);
        check("rd_c5_rdata", 64'(cli_rdata), 64'h0);
        check("rd_c5_grant", 64'(grant), 64'h0);
        $display("txn single read done");

        // Single write, client 1; input change after grant must be ignored
        cli_write_en[1]     = 1'b1;
        cli_addr[AW +: AW]  = 32'h20;
        cli_wdata[DW +: DW] = 8'h3C;
        tick;
        check("wr_wren", 64'(mem_write_en), 64'h1);
        check("wr_rden", 64'(mem_read_en), 64'h0);
        check("wr_addr", 64'(mem_addr), 64'h20);
        check("wr_data", 64'(mem_data_in), 64'h3C);
        check("wr_grant", 64'(grant), 64'h2);
        cli_wdata[DW +: DW] = 8'hFF;
        cli_addr[AW +: AW]  = 32'h99;
        tick;
        mem_ready    = 1'b1;
        mem_data_out = 8'h77;
        check("wr_wait_wren", 64'(mem_write_en), 64'h0);
        tick;
        mem_ready = 1'b0;
        check("wr_ready", 64'(cli_ready), 64'h2);
        check("wr_rdata", 64'(cli_rdata), 64'h0);
        check("wr_stable_data", 64'(mem_data_in), 64'h3C);
        check("wr_stable_addr", 64'(mem_addr), 64'h20);
        cli_write_en[1] = 1'b0;
        tick;
        check("wr_idle_ready", 64'(cli_ready), 64'h0);
        $display("txn single write done");

        // Contention: both clients request continuously
        cli_read_en        = 2'b11;
        cli_addr[0 +: AW]  = 32'h100;
        cli_addr[AW +: AW] = 32'h200;
        mem_data_out       = 8'h11;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            tick;
            check("cont_grant", 64'(grant), 64'(exp_g));
            check("cont_addr", 64'(mem_addr), (exp_g == 2'b01) ? 64'h100 : 64'h200);
            mem_ready = 1'b1;
            tick;
            tick;
            mem_ready = 1'b0;
            check("cont_ready", 64'(cli_ready), 64'(exp_g));
            tick;
            check("cont_idle_ready", 64'(cli_ready), 64'h0);
            $display("txn contention %0d winner=%b", t, exp_g);
        end
        cli_read_en = 2'b00;
        tick;

        // Timeout: TIMEOUT_CYCLES=4, memory never responds
        cli_read_en[0]    = 1'b1;
        cli_addr[0 +: AW] = 32'h30;
        mem_data_out      = 8'hEE;
        tick;
        check("to_rden", 64'(mem_read_en), 64'h1);
        waited = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            waited++;
            if (cli_ready != '0) break;
        end
        check("to_latency", 64'(waited), 64'd5);
        check("to_ready", 64'(cli_ready), 64'h1);
        check("to_err", 64'(cli_err), 64'h1);
        check("to_rdata", 64'(cli_rdata), 64'h0);
        cli_read_en[0] = 1'b0;
        tick;
        check("to_idle_err", 64'(cli_err), 64'h0);
        $display("txn timeout done");

        // Normal request after timeout
        cli_read_en[0] = 1'b1;
        mem_data_out   = 8'h5A;
        tick;
        mem_ready = 1'b1;
        tick;
        tick;
        mem_ready = 1'b0;
        check("post_to_ready", 64'(cli_ready), 64'h1);
        check("post_to_rdata", 64'(cli_rdata), 64'h5A);
        check("post_to_err", 64'(cli_err), 64'h0);
        cli_read_en[0] = 1'b0;
        tick;
        $display("txn post-timeout read done");

        // Reset during WAIT
        cli_read_en[1]     = 1'b1;
        cli_addr[AW +: AW] = 32'h50;
        tick;
        tick;
        check("rw_grant_pre", 64'(grant), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_grant_async", 64'(grant), 64'h0);
        check("rw_ready_async", 64'(cli_ready), 64'h0);
        cli_read_en[0]    = 1'b1;
        cli_addr[0 +: AW] = 32'h40;
        mem_ready         = 1'b1;
        tick;
        check("rw_ready_held", 64'(cli_ready), 64'h0);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        tick;
        check("rw_first_grant", 64'(grant), 64'h1);
        check("rw_first_addr", 64'(mem_addr), 64'h40);
        mem_ready    = 1'b1;
        mem_data_out = 8'h3D;
        tick;
        tick;
        mem_ready = 1'b0;
        check("rw_first_ready", 64'(cli_ready), 64'h1);
        check("rw_first_rdata", 64'(cli_rdata), 64'h3D);
        cli_read_en = 2'b00;
        tick;
        $display("txn reset mid-wait done");

        // Read and write together on client 0 -> treated as write
        cli_read_en[0]    = 1'b1;
        cli_write_en[0]   = 1'b1;
        cli_addr[0 +: AW] = 32'h60;
        cli_wdata[0 +: DW] = 8'h81;
        tick;
        check("rw_both_wren", 64'(mem_write_en), 64'h1);
        check("rw_both_rden", 64'(mem_read_en), 64'h0);
        check("rw_both_data", 64'(mem_data_in), 64'h81);
        mem_ready    = 1'b1;
        mem_data_out = 8'h42;
        tick;
        check("rw_both_wait_rden", 64'(mem_read_en), 64'h0);
        tick;
        mem_ready = 1'b0;
        check("rw_both_ready", 64'(cli_ready), 64'h1);
        check("rw_both_rdata", 64'(cli_rdata), 64'h0);
        check("rw_both_resp_rden", 64'(mem_read_en), 64'h0);
        cli_read_en  = 2'b00;
        cli_write_en = 2'b00;
        tick;
        $display("txn read+write collision done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
